button_conditioner: RTL and testbench

Input conditioning stage that sits directly upstream of the 4-bit processor's `pushbuttons` port. It synchronises four raw mechanical push-button inputs into the processor clock domain and debounces each one independently. It drives stable, glitch-free button levels to the processor's input bus driver, plus one-cycle press and release strobes for status and LED logic.

---
 rtl/button_conditioner.sv | 116 +++++++++++
 tb/tb_button_conditioner.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: two-flop synchroniser and independent per-bit debounce
// counters for four push-buttons, with registered press/release strobes.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter bit          ACTIVE_LOW      = 1'b0,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_clean,
    output logic [3:0] btn_press,
    output logic [3:0] btn_release,
    output logic       any_press
);

    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_ACCEPT
    } step_e;

    logic [3:0] btn_in;
    logic [3:0] s1_q;
    logic [3:0] s2_q;
    logic [3:0] press_d_vec;
    logic       any_press_q;

    // Normalise polarity so 1 always means pressed from here on.
    assign btn_in = ACTIVE_LOW ? ~btn_raw : btn_raw;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= btn_in;
            s2_q <= s1_q;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_bit
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             clean_q;
        logic             clean_d;
        logic             press_q;
        logic             press_d;
        logic             release_q;
        logic             release_d;
        step_e            step;

        // Any cycle where the input agrees with the clean level restarts the count.
        always_comb begin
            if (s2_q[i] == clean_q) begin
                step = ST_IDLE;
            end else if (cnt_q == TERMINAL) begin
                step = ST_ACCEPT;
            end else begin
                step = ST_COUNT;
            end
        end

        always_comb begin
            cnt_d     = '0;
            clean_d   = clean_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            unique case (step)
                ST_COUNT: begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                ST_ACCEPT: begin
                    clean_d   = s2_q[i];
                    press_d   = s2_q[i];
                    release_d = ~s2_q[i];
                end
                default: begin
                end
            endcase
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt_q     <= '0;
                clean_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                clean_q   <= clean_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign btn_clean[i]   = clean_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign press_d_vec[i] = press_d;
    end

    // Registered from the next-state strobes so it lines up with btn_press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |press_d_vec;
        end
    end

    assign any_press = any_press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: windowed reference model checked every cycle,
// plus directed literal checks on latency, glitch rejection and reset.
module tb_button_conditioner;

    localparam int N = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] raw_a, raw_b;
    logic [3:0] clean_a, press_a, rel_a;
    logic [3:0] clean_b, press_b, rel_b;
    logic       any_a, any_b;

    int total = 0;
    int bad   = 0;

    // hist[k][j] = pressed-polarity input sampled j edges ago for instance k
    logic [3:0] hist    [2][N+2];
    logic [3:0] m_clean [2];
    logic [3:0] m_press [2];
    logic [3:0] m_rel   [2];

    button_conditioner #(.DEBOUNCE_CYCLES(N), .ACTIVE_LOW(1'b0)) u_a (
        .clock(clock), .reset(reset), .btn_raw(raw_a),
        .btn_clean(clean_a), .btn_press(press_a), .btn_release(rel_a),
        .any_press(any_a)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(N), .ACTIVE_LOW(1'b1)) u_b (
        .clock(clock), .reset(reset), .btn_raw(raw_b),
        .btn_clean(clean_b), .btn_press(press_b), .btn_release(rel_b),
        .any_press(any_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // A bit is accepted when the last N synchronised samples all disagree
    // with its clean level; synchronised sample = input from two edges ago.
    always @(posedge clock or posedge reset) begin
        logic [3:0] acc;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j < N + 2; j++) hist[k][j] = '0;
                m_clean[k] = '0;
                m_press[k] = '0;
                m_rel[k]   = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int j = N + 1; j > 0; j--) hist[k][j] = hist[k][j-1];
                hist[k][0] = (k == 0) ? raw_a : ~raw_b;
                acc = '0;
                for (int b = 0; b < 4; b++) begin
                    acc[b] = 1'b1;
                    for (int j = 2; j <= N + 1; j++)
                        if (hist[k][j][b] == m_clean[k][b]) acc[b] = 1'b0;
                end
                m_press[k] = acc & hist[k][2];
                m_rel[k]   = acc & ~hist[k][2];
                m_clean[k] = m_clean[k] ^ acc;
            end
        end
    end

    always @(negedge clock) begin
        check("A.clean",   clean_a,          m_clean[0]);
        check("A.press",   press_a,          m_press[0]);
        check("A.release", rel_a,            m_rel[0]);
        check("A.any",     {3'b000, any_a},  {3'b000, |m_press[0]});
        check("B.clean",   clean_b,          m_clean[1]);
        check("B.press",   press_b,          m_press[1]);
        check("B.release", rel_b,            m_rel[1]);
        check("B.any",     {3'b000, any_b},  {3'b000, |m_press[1]});
    end

    initial begin
        logic [3:0] acc;
        reset = 1'b1;
        raw_a = 4'h0;
        raw_b = 4'hF;
        tick(3);
        check("rst.clean",   clean_a, 4'h0);
        check("rst.press",   press_a, 4'h0);
        check("rst.any",     {3'b000, any_a}, 4'h0);
        reset = 1'b0;
        tick(4);
        check("al.idle", clean_b, 4'h0);

        // Clean press and release on bit 0
        raw_a = 4'h1;
        tick(5);
        check("press.early", clean_a, 4'h0);
        tick(1);
        check("press.clean", clean_a, 4'h1);
        check("press.strobe", press_a, 4'h1);
        check("press.any", {3'b000, any_a}, 4'h1);
        tick(1);
        check("press.drop", press_a, 4'h0);
        check("press.hold", clean_a, 4'h1);
        raw_a = 4'h0;
        tick(6);
        check("rel.strobe", rel_a, 4'h1);
        check("rel.clean", clean_a, 4'h0);
        tick(1);
        check("rel.drop", rel_a, 4'h0);

        // Bounce on bit 2, then hold
        acc = '0;
        for (int t = 0; t < 8; t++) begin
            raw_a = ((t / 2) % 2 == 0) ? 4'h4 : 4'h0;
            tick(1);
            acc = acc | press_a | rel_a;
        end
        raw_a = 4'h4;
        for (int t = 0; t < 5; t++) begin
            tick(1);
            acc = acc | press_a | rel_a;
        end
        check("bounce.nostrobe", acc, 4'h0);
        check("bounce.early", clean_a, 4'h0);
        tick(1);
        check("bounce.clean", clean_a, 4'h4);
        check("bounce.press", press_a, 4'h4);
        raw_a = 4'h0;
        tick(8);

        // 3-cycle glitch on bit 1
        acc = '0;
        for (int t = 0; t < 13; t++) begin
            raw_a = (t < 3) ? 4'h2 : 4'h0;
            tick(1);
            acc = acc | clean_a | press_a | rel_a;
        end
        check("glitch.quiet", acc, 4'h0);

        // Simultaneous bits 1 and 3
        raw_a = 4'hA;
        tick(6);
        check("simul.press", press_a, 4'hA);
        check("simul.clean", clean_a, 4'hA);
        check("simul.any", {3'b000, any_a}, 4'h1);
        tick(1);
        check("simul.drop", press_a, 4'h0);
        check("simul.anydrop", {3'b000, any_a}, 4'h0);

        // Active-low instance: bit 3 pulled low
        raw_b = 4'h7;
        tick(6);
        check("al.clean", clean_b, 4'h8);
        check("al.press", press_b, 4'h8);

        // Asynchronous reset mid-run with all buttons held
        raw_a = 4'hF;
        tick(8);
        check("hold.clean", clean_a, 4'hF);
        #2;
        reset = 1'b1;
        #1;
        check("arst.clean_a", clean_a, 4'h0);
        check("arst.press_a", press_a | rel_a, 4'h0);
        check("arst.clean_b", clean_b, 4'h0);
        tick(2);
        reset = 1'b0;
        tick(5);
        check("post.early", clean_a, 4'h0);
        tick(1);
        check("post.press_a", press_a, 4'hF);
        check("post.press_b", press_b, 4'h8);

        // Reset in the middle of a release count: no release strobe afterwards
        raw_a = 4'h0;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        acc = '0;
        for (int t = 0; t < 8; t++) begin
            tick(1);
            acc = acc | rel_a | clean_a;
        end
        check("midrst.quiet", acc, 4'h0);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
